// File: rtl/uart_io_master.sv
// rtl/uart_io_master.sv - UART command bridge that reads and writes the 8-bit I/O bus
module uart_io_master #(
    parameter int clk_freq = 10000000,
    parameter int baud     = 9600,
    parameter int divisor  = clk_freq / baud / 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       ser_rx,
    output logic       ser_tx,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [5:0] io_a,
    output logic       io_we,
    output logic       io_re,
    output logic [7:0] io_do,
    input  logic [7:0] io_di,
    output logic       busy,
    output logic       rx_err
);
    localparam int BIT_CYC = 16 * divisor;
    localparam int CW = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {CMD, WDATA, REQ, ACC, CAP, SEND} cmd_state_t;

    logic            rx_m, rx_s, rx_q;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_valid, rx_ferr;

    cmd_state_t      state;
    logic            is_write;
    logic [5:0]      cmd_addr;
    logic [7:0]      wdata;
    logic [8:0]      tx_shift;
    logic [3:0]      tx_bit;
    logic [CW-1:0]   tx_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            {rx_m, rx_s, rx_q} <= 3'b111;
        end else begin
            rx_m <= ser_rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    // Receiver: the counter restarts on the start edge so samples land mid-bit.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                R_IDLE: if (rx_q && !rx_s) begin
                    rx_state <= R_START;
                    rx_cnt   <= '0;
                end
                R_START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                R_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7)
                        rx_state <= R_STOP;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                default: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_state <= R_IDLE;
                    rx_valid <= rx_s;
                    rx_ferr  <= !rx_s;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= CMD;
            is_write <= 1'b0;
            cmd_addr <= '0;
            wdata    <= '0;
            io_a     <= '0;
            io_do    <= '0;
            io_we    <= 1'b0;
            io_re    <= 1'b0;
            bus_req  <= 1'b0;
            busy     <= 1'b0;
            rx_err   <= 1'b0;
            ser_tx   <= 1'b1;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_cnt   <= '0;
        end else begin
            io_we  <= 1'b0;
            io_re  <= 1'b0;
            rx_err <= 1'b0;
            if (rx_ferr) begin
                // A broken frame abandons whatever command was in progress.
                state   <= CMD;
                bus_req <= 1'b0;
                busy    <= 1'b0;
                ser_tx  <= 1'b1;
                rx_err  <= 1'b1;
            end else begin
                if (rx_valid && state != CMD && state != WDATA)
                    rx_err <= 1'b1;
                case (state)
                    CMD: if (rx_valid) begin
                        if (rx_shift[6]) begin
                            rx_err <= 1'b1;
                        end else begin
                            cmd_addr <= rx_shift[5:0];
                            is_write <= rx_shift[7];
                            busy     <= 1'b1;
                            if (rx_shift[7]) begin
                                state <= WDATA;
                            end else begin
                                state   <= REQ;
                                bus_req <= 1'b1;
                            end
                        end
                    end
                    WDATA: if (rx_valid) begin
                        wdata   <= rx_shift;
                        state   <= REQ;
                        bus_req <= 1'b1;
                    end
                    REQ: if (bus_gnt) begin
                        state <= ACC;
                        io_a  <= cmd_addr;
                        io_we <= is_write;
                        io_re <= !is_write;
                        if (is_write)
                            io_do <= wdata;
                    end
                    ACC: if (is_write) begin
                        state   <= CMD;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        state <= CAP;
                    end
                    CAP: begin
                        tx_shift <= {1'b1, io_di};
                        ser_tx   <= 1'b0;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        bus_req  <= 1'b0;
                        state    <= SEND;
                    end
                    default: if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            state <= CMD;
                            busy  <= 1'b0;
                        end else begin
                            ser_tx   <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[8:1]};
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/uart_io_master.md
# uart_io_master

Serial-to-I/O-bus bridge. It receives 8N1 command frames on a UART line and performs single-cycle reads and writes on the 8-bit, 6-bit-address I/O bus as a bus initiator. Read results are returned as one 8N1 byte. It sits beside the CPU: it arbitrates for the I/O bus with a req/gnt handshake and is used for debug peeking and poking and for boot-time loading of peripherals such as the UART, timers and ports.

## Interface
- `clk_freq`, default 10000000: sys_clk frequency in Hz.
- `baud`, default 9600: line rate; the link is 8 data bits, no parity, 1 stop bit.
- `divisor`, default `clk_freq/baud/16` (65): sys_clk cycles per 16x oversample tick.

- `sys_clk` in 1: clock, rising edge.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `ser_rx` in 1: serial input, idle high; synchronized internally with 2 flops.
- `ser_tx` out 1: serial output, idle high.
- `bus_req` out 1: request for ownership of the I/O bus.
- `bus_gnt` in 1: grant from the CPU/arbiter; must stay high until `bus_req` falls.
- `io_a` out 6: I/O address.
- `io_we` out 1: write strobe, one cycle.
- `io_re` out 1: read strobe, one cycle.
- `io_do` out 8: write data to peripherals.
- `io_di` in 8: read data from peripherals. It is registered in the peripherals, so it is valid in the cycle after `io_re`.
- `busy` out 1: high whenever the command FSM is not in CMD.
- `rx_err` out 1: one-cycle pulse on a framing error or a dropped byte.

## Operation
- Command byte format: bit7 = 1 write / 0 read; bit6 must be 0; bits5:0 = address.
  - Bit6 = 1: byte discarded, `rx_err` pulses, FSM stays in CMD.
- Write transaction: command byte then data byte. No reply.
- Read transaction: command byte only. Reply is one byte containing `io_di`.
- Receiver:
  - A falling edge of the synchronized `ser_rx` starts a frame.
  - Start bit is re-checked at tick 8; if `ser_rx` is high there, the edge was a glitch and the receiver returns to idle.
  - Data bits are sampled every 16 ticks after that, LSB first, then the stop bit.
  - Stop bit = 0: framing error. Byte dropped, `rx_err` pulses, and the command FSM is forced to CMD, which aborts a half-received write.
  - A good byte gives a one-cycle `rx_valid` internally, in the cycle after the stop-bit sample.
- Command FSM states: CMD, WDATA, REQ, ACC, CAP, SEND.
  - CMD, `rx_valid` with bit6 = 0: latch the address. Write → WDATA; read → REQ.
  - WDATA, `rx_valid`: latch the data → REQ.
  - REQ: `bus_req` = 1; wait for `bus_gnt` = 1 → ACC. Waiting is unbounded.
  - ACC: drive `io_a`, plus `io_we` with `io_do` (write) or `io_re` (read), for exactly one cycle. Write → CMD; read → CAP.
  - CAP: latch `io_di` into the tx shift register → SEND.
  - SEND: transmit the byte; on stop-bit end → CMD.
- `bus_req` is high from REQ through ACC for writes, and through CAP for reads. It is low in all other states.
- `io_a` and `io_do` are held at their last values outside ACC. `io_we` and `io_re` are 0 outside ACC.
- Bytes arriving in REQ, ACC, CAP or SEND are dropped with an `rx_err` pulse. There is no buffering.
- Transmitter: start bit, 8 data bits LSB first, stop bit. Each bit lasts 16 ticks.

## Timing
- Reset values: `ser_tx` = 1, `bus_req` = 0, `io_a` = 0, `io_we` = 0, `io_re` = 0, `io_do` = 0, `busy` = 0, `rx_err` = 0. FSM in CMD, receiver and transmitter idle, tick counter 0.
- Reset mid-frame or mid-access: all outputs return to their reset values asynchronously, and `ser_tx` goes high immediately.
- Tick period = `divisor` cycles. Bit time = 16 × `divisor` = 1040 cycles at the defaults. Frame = 10400 cycles.
- `bus_gnt` is sampled high in REQ at cycle N: `io_we`/`io_re` is high in cycle N+1. For a write, `bus_req` is low in N+2.
- Read: `io_re` at cycle N+1, `io_di` captured at N+2 (CAP), `ser_tx` start bit begins at N+3.
- `rx_valid` and a `bus_gnt` already high: the first strobe follows 2 cycles after `rx_valid` (CMD/WDATA → REQ → ACC).
- The tx tick counter restarts at the start of SEND, so every bit lasts exactly 16 × `divisor` cycles with no jitter.

## Test plan
- Write path:
  - Stimulus: send 0x8D then 0x55, `bus_gnt` tied high.
  - Response: one cycle with `io_we` = 1, `io_a` = 0x0D, `io_do` = 0x55. No `ser_tx` activity. `bus_req` asserted for exactly 2 cycles.
- Read path:
  - Stimulus: send 0x0F, model drives `io_di` = 0xA7 in the cycle after `io_re`.
  - Response: `io_re` for one cycle with `io_a` = 0x0F. `ser_tx` emits 0xA7 with 1040-cycle bits.
- Grant stall:
  - Stimulus: hold `bus_gnt` low for 50 cycles after `bus_req` rises.
  - Response: no strobe before the grant. Strobe exactly 1 cycle after `bus_gnt` is sampled high.
- Framing error:
  - Stimulus: send 0x8D, then a data byte with stop bit = 0.
  - Response: `rx_err` pulses, no `io_we`, FSM back in CMD. A following 0x0C is executed as a read.
- Drop and reserved bit:
  - Stimulus: send 0x4C. Then send a byte during a read reply.
  - Response: both dropped with an `rx_err` pulse. The reply byte is transmitted intact.
- Reset mid-transmit:
  - Stimulus: assert `sys_rst` during the data bits of a reply.
  - Response: `ser_tx` = 1, `bus_req` = 0, `busy` = 0 immediately. The next command works normally.
